// File: rtl/reg_file_pkg.sv
// Shared CPU package: register-file widths, the zero-register address and
// the address type reused by decode and hazard logic.
package reg_file_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 4'h0;
endpackage

// File: rtl/reg_file_reg16_en.sv
// DATA_W-bit flop bank with synchronous load enable and asynchronous
// active-low clear. One instance per architectural register R1..R15.
module reg16_en #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Hold the current value unless this register is the write target.
    always_comb begin
        data_d = data_q;
        if (en_i) data_d = d_i;
    end

    // State register; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

// File: rtl/reg_file.sv
// Architectural register file: NREGS x DATA_W, two combinational read ports,
// one clocked write port, R0 hard-wired to zero, optional write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int NREGS  = 16,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] src_reg1,
    input  logic [$clog2(NREGS)-1:0] src_reg2,
    input  logic [$clog2(NREGS)-1:0] dst_reg,
    input  logic                     write_reg,
    input  logic [DATA_W-1:0]        dst_data,
    output logic [DATA_W-1:0]        src_data1,
    output logic [DATA_W-1:0]        src_data2
);
    logic [NREGS-1:0]  wr_en;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // One-hot write decode gated by write_reg; the R0 bit never fires, so
    // writes to R0 are dropped and R0 can never be a bypass source either.
    always_comb begin
        wr_en = '0;
        if (write_reg) wr_en[dst_reg] = 1'b1;
        wr_en[0] = 1'b0;
    end

    // R0 is not stored: its mux input is a constant zero.
    assign regs_q[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        reg16_en #(.DATA_W(DATA_W)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (wr_en[i]),
            .d_i   (dst_data),
            .q_o   (regs_q[i])
        );
    end

    // Word select per port followed by the 2:1 bypass select. wr_en[src]
    // is high exactly when a live, non-R0 write targets the read address.
    always_comb begin
        rd1 = regs_q[src_reg1];
        rd2 = regs_q[src_reg2];
        if (BYPASS != 0) begin
            if (wr_en[src_reg1]) rd1 = dst_data;
            if (wr_en[src_reg2]) rd2 = dst_data;
        end
    end

    // While reset is asserted both ports read zero, bypass included.
    assign src_data1 = rst_n ? rd1 : '0;
    assign src_data2 = rst_n ? rd2 : '0;
endmodule
